// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: registered command front end for the combinational ALU; `ALU_SEQ_WIDE_EN adds a chained high pass for 2*WIDTH ops.
// Latency: rsp_valid rises 2 cycles after the accept cycle for narrow ops, 3 cycles for wide ops.
// Backpressure: response held in RESP until rsp_ready; a new command is taken only from IDLE or on the RESP handshake.
module alu_op_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_cmd_valid,
    output logic               o_cmd_ready,
    input  logic [3:0]         i_cmd_select,
    input  logic               i_cmd_mode,
    input  logic               i_cmd_carry_in,
    input  logic               i_cmd_wide,
    input  logic [2*WIDTH-1:0] i_cmd_a,
    input  logic [2*WIDTH-1:0] i_cmd_b,
    output logic [WIDTH-1:0]   o_alu_a,
    output logic [WIDTH-1:0]   o_alu_b,
    output logic [3:0]         o_alu_select,
    output logic               o_alu_mode,
    output logic               o_alu_carry_in,
    input  logic [WIDTH-1:0]   i_alu_result,
    input  logic               i_alu_carry_out,
    input  logic               i_alu_compare,
    output logic               o_rsp_valid,
    input  logic               i_rsp_ready,
    output logic [2*WIDTH-1:0] o_rsp_result,
    output logic               o_rsp_carry,
    output logic               o_rsp_equal
);

`ifdef ALU_SEQ_WIDE_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_LO = 2'd1, S_HI = 2'd2, S_RESP = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_LO = 2'd1, S_RESP = 2'd3} state_t;
`endif

    state_t           r_state, w_nxt_state;
    logic [WIDTH-1:0] r_alu_a, r_alu_b, w_nxt_alu_a, w_nxt_alu_b;
    logic [3:0]       r_alu_select, w_nxt_alu_select;
    logic             r_alu_mode, w_nxt_alu_mode;
    logic             r_alu_carry_in, w_nxt_alu_carry_in;
    logic [WIDTH-1:0] r_rsp_lo, r_rsp_hi, w_nxt_rsp_lo, w_nxt_rsp_hi;
    logic             r_rsp_carry, w_nxt_rsp_carry;
    logic             r_rsp_equal, w_nxt_rsp_equal;
    logic             w_cmd_ready, w_accept, w_load;

`ifdef ALU_SEQ_WIDE_EN
    logic             r_wide, w_nxt_wide;
    logic [WIDTH-1:0] r_a_hi, r_b_hi, w_nxt_a_hi, w_nxt_b_hi;
`else
    logic             w_unused_hi;
    assign w_unused_hi = ^{i_cmd_wide, i_cmd_a[2*WIDTH-1:WIDTH], i_cmd_b[2*WIDTH-1:WIDTH]};
`endif

    assign w_cmd_ready = !i_rst && ((r_state == S_IDLE) || ((r_state == S_RESP) && i_rsp_ready));
    assign w_accept    = i_cmd_valid && w_cmd_ready;

    always_comb begin
        w_nxt_state        = r_state;
        w_nxt_alu_a        = r_alu_a;
        w_nxt_alu_b        = r_alu_b;
        w_nxt_alu_select   = r_alu_select;
        w_nxt_alu_mode     = r_alu_mode;
        w_nxt_alu_carry_in = r_alu_carry_in;
        w_nxt_rsp_lo       = r_rsp_lo;
        w_nxt_rsp_hi       = r_rsp_hi;
        w_nxt_rsp_carry    = r_rsp_carry;
        w_nxt_rsp_equal    = r_rsp_equal;
        w_load             = 1'b0;
`ifdef ALU_SEQ_WIDE_EN
        w_nxt_wide         = r_wide;
        w_nxt_a_hi         = r_a_hi;
        w_nxt_b_hi         = r_b_hi;
`endif
        case (r_state)
            S_IDLE: begin
                w_load = w_accept;
            end
            S_LO: begin
                w_nxt_rsp_lo    = i_alu_result;
                w_nxt_rsp_carry = i_alu_carry_out;
                w_nxt_rsp_equal = i_alu_compare;
`ifdef ALU_SEQ_WIDE_EN
                if (r_wide) begin
                    // low-pass carry feeds the high pass in either ALU mode
                    w_nxt_alu_a        = r_a_hi;
                    w_nxt_alu_b        = r_b_hi;
                    w_nxt_alu_carry_in = i_alu_carry_out;
                    w_nxt_state        = S_HI;
                end else begin
                    w_nxt_rsp_hi = '0;
                    w_nxt_state  = S_RESP;
                end
`else
                w_nxt_rsp_hi = '0;
                w_nxt_state  = S_RESP;
`endif
            end
`ifdef ALU_SEQ_WIDE_EN
            S_HI: begin
                w_nxt_rsp_hi    = i_alu_result;
                w_nxt_rsp_carry = i_alu_carry_out;
                w_nxt_rsp_equal = r_rsp_equal & i_alu_compare;
                w_nxt_state     = S_RESP;
            end
`endif
            S_RESP: begin
                if (i_rsp_ready) begin
                    w_load      = w_accept;
                    w_nxt_state = S_IDLE;
                end
            end
            default: begin
                w_nxt_state = S_IDLE;
            end
        endcase

        if (w_load) begin
            w_nxt_state        = S_LO;
            w_nxt_alu_a        = i_cmd_a[WIDTH-1:0];
            w_nxt_alu_b        = i_cmd_b[WIDTH-1:0];
            w_nxt_alu_select   = i_cmd_select;
            w_nxt_alu_mode     = i_cmd_mode;
            w_nxt_alu_carry_in = i_cmd_carry_in;
`ifdef ALU_SEQ_WIDE_EN
            w_nxt_wide         = i_cmd_wide;
            w_nxt_a_hi         = i_cmd_a[2*WIDTH-1:WIDTH];
            w_nxt_b_hi         = i_cmd_b[2*WIDTH-1:WIDTH];
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= S_IDLE;
            r_alu_a        <= '0;
            r_alu_b        <= '0;
            r_alu_select   <= '0;
            r_alu_mode     <= 1'b0;
            r_alu_carry_in <= 1'b0;
            r_rsp_lo       <= '0;
            r_rsp_hi       <= '0;
            r_rsp_carry    <= 1'b0;
            r_rsp_equal    <= 1'b0;
`ifdef ALU_SEQ_WIDE_EN
            r_wide         <= 1'b0;
            r_a_hi         <= '0;
            r_b_hi         <= '0;
`endif
        end else begin
            r_state        <= w_nxt_state;
            r_alu_a        <= w_nxt_alu_a;
            r_alu_b        <= w_nxt_alu_b;
            r_alu_select   <= w_nxt_alu_select;
            r_alu_mode     <= w_nxt_alu_mode;
            r_alu_carry_in <= w_nxt_alu_carry_in;
            r_rsp_lo       <= w_nxt_rsp_lo;
            r_rsp_hi       <= w_nxt_rsp_hi;
            r_rsp_carry    <= w_nxt_rsp_carry;
            r_rsp_equal    <= w_nxt_rsp_equal;
`ifdef ALU_SEQ_WIDE_EN
            r_wide         <= w_nxt_wide;
            r_a_hi         <= w_nxt_a_hi;
            r_b_hi         <= w_nxt_b_hi;
`endif
        end
    end

    assign o_cmd_ready    = w_cmd_ready;
    assign o_alu_a        = r_alu_a;
    assign o_alu_b        = r_alu_b;
    assign o_alu_select   = r_alu_select;
    assign o_alu_mode     = r_alu_mode;
    assign o_alu_carry_in = r_alu_carry_in;
    assign o_rsp_valid    = (r_state == S_RESP);
    assign o_rsp_result   = {r_rsp_hi, r_rsp_lo};
    assign o_rsp_carry    = r_rsp_carry;
    assign o_rsp_equal    = r_rsp_equal;

endmodule
